// File: rtl/acc_pkg.sv
// Shared types for the accelerator response path: extended request ID and
// the response channel bundle, plus a pointer-width helper.
package acc_pkg;

    localparam int unsigned ExtIdWidth = 2;
    localparam int unsigned DataWidth  = 32;

    typedef logic [ExtIdWidth-1:0] ext_id_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic                 error;
        ext_id_t              id;
    } acc_rsp_chan_t;

    // A single-entry FIFO still needs a one-bit pointer to index its storage.
    function automatic int unsigned ptr_width(input int unsigned depth);
        if (depth > 32'd1) begin
            return $clog2(depth);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/acc_rsp_id_tracker_if.sv
// Request/response handshake bundle between interconnect, tracker and accelerator.
// slave = tracker side, master = environment side.
interface acc_rsp_id_tracker_if import acc_pkg::*; #(
    parameter int unsigned DataWidth  = acc_pkg::DataWidth,
    parameter int unsigned ExtIdWidth = acc_pkg::ExtIdWidth
) ();

    logic                  slv_q_valid;
    logic                  slv_q_ready;
    logic [ExtIdWidth-1:0] slv_q_id;
    logic                  slv_q_wb;
    logic                  acc_q_valid;
    logic                  acc_q_ready;
    logic                  acc_p_valid;
    logic                  acc_p_ready;
    logic [DataWidth-1:0]  acc_p_data;
    logic                  acc_p_error;
    logic                  slv_p_valid;
    logic                  slv_p_ready;
    logic [DataWidth-1:0]  slv_p_data;
    logic                  slv_p_error;
    logic [ExtIdWidth-1:0] slv_p_id;

    modport slave (
        input  slv_q_valid, slv_q_id, slv_q_wb, acc_q_ready,
        input  acc_p_valid, acc_p_data, acc_p_error, slv_p_ready,
        output slv_q_ready, acc_q_valid, acc_p_ready,
        output slv_p_valid, slv_p_data, slv_p_error, slv_p_id
    );

    modport master (
        output slv_q_valid, slv_q_id, slv_q_wb, acc_q_ready,
        output acc_p_valid, acc_p_data, acc_p_error, slv_p_ready,
        input  slv_q_ready, acc_q_valid, acc_p_ready,
        input  slv_p_valid, slv_p_data, slv_p_error, slv_p_id
    );

endinterface

// File: rtl/acc_id_fifo.sv
// Small ID FIFO: circular storage with read/write pointers and a fill counter.
// Push is ignored when full and pop when empty.
module acc_id_fifo import acc_pkg::*; #(
    parameter int unsigned Depth      = 4,
    parameter int unsigned ExtIdWidth = 2,
    parameter int unsigned CntWidth   = $clog2(Depth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [ExtIdWidth-1:0] id_i,
    output logic [ExtIdWidth-1:0] id_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CntWidth-1:0]   count_o
);

    localparam int unsigned PtrWidth = ptr_width(Depth);

    logic [ExtIdWidth-1:0] mem_q [Depth];
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]   count_q,  count_d;
    logic                  push_ok_s, pop_ok_s;

    function automatic logic [PtrWidth-1:0] inc_ptr(input logic [PtrWidth-1:0] ptr);
        if (ptr == PtrWidth'(Depth - 1)) begin
            return {PtrWidth{1'b0}};
        end else begin
            return ptr + PtrWidth'(1);
        end
    endfunction

    assign full_o    = (count_q == CntWidth'(Depth));
    assign empty_o   = (count_q == {CntWidth{1'b0}});
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;
    assign id_o      = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Next pointer and fill-level computation.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = inc_ptr(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = inc_ptr(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CntWidth'(1);
            2'b01:   count_d = count_q - CntWidth'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PtrWidth{1'b0}};
            rd_ptr_q <= {PtrWidth{1'b0}};
            count_q  <= {CntWidth{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ID storage; stale entries are unreachable once the pointers reset.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= id_i;
        end
    end

endmodule

// File: rtl/acc_rsp_id_tracker.sv
// Re-attaches extended IDs to in-order accelerator responses and bounds outstanding
// writeback requests. ACC_RSP_ID_TRACKER_SPILL_EN registers the response path.
module acc_rsp_id_tracker import acc_pkg::*; #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned ExtIdWidth = 2,
    parameter int unsigned Depth      = 4,
    parameter int unsigned CntWidth   = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    acc_rsp_id_tracker_if.slave  bus,
    output logic [CntWidth-1:0]  outstanding_o,
    output logic                 spurious_o
);

    logic                  full_s, empty_s, blocked_s, push_s, pop_s;
    logic [ExtIdWidth-1:0] head_id_s;
    logic [DataWidth-1:0]  rsp_data_s;

    acc_id_fifo #(
        .Depth      (Depth),
        .ExtIdWidth (ExtIdWidth),
        .CntWidth   (CntWidth)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .id_i    (bus.slv_q_id),
        .id_o    (head_id_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (outstanding_o)
    );

    // Only writeback requests need a slot; a pop in the same cycle cannot free one.
    assign blocked_s       = bus.slv_q_wb & full_s;
    assign bus.acc_q_valid = bus.slv_q_valid & ~blocked_s;
    assign bus.slv_q_ready = bus.acc_q_ready & ~blocked_s;
    assign push_s          = bus.slv_q_valid & bus.slv_q_ready & bus.slv_q_wb;

    assign rsp_data_s = bus.acc_p_data;
    assign spurious_o = bus.acc_p_valid & empty_s;

`ifdef ACC_RSP_ID_TRACKER_SPILL_EN
    logic                  spill_full_q, spill_full_d;
    logic [ExtIdWidth-1:0] spill_id_q,   spill_id_d;
    logic [DataWidth-1:0]  spill_data_q, spill_data_d;
    logic                  spill_err_q,  spill_err_d;
    logic                  load_s, drain_s;

    assign drain_s         = spill_full_q & bus.slv_p_ready;
    assign load_s          = bus.acc_p_valid & ~empty_s & (~spill_full_q | bus.slv_p_ready);
    assign pop_s           = load_s;
    assign bus.acc_p_ready = ~spill_full_q | bus.slv_p_ready | empty_s;
    assign bus.slv_p_valid = spill_full_q;
    assign bus.slv_p_id    = spill_id_q;
    assign bus.slv_p_data  = spill_data_q;
    assign bus.slv_p_error = spill_err_q;

    // Spill register next state: load wins over drain so throughput stays 1/cycle.
    always_comb begin
        spill_full_d = spill_full_q;
        spill_id_d   = spill_id_q;
        spill_data_d = spill_data_q;
        spill_err_d  = spill_err_q;
        if (load_s) begin
            spill_full_d = 1'b1;
            spill_id_d   = head_id_s;
            spill_data_d = rsp_data_s;
            spill_err_d  = bus.acc_p_error;
        end else if (drain_s) begin
            spill_full_d = 1'b0;
        end else begin
            spill_full_d = spill_full_q;
        end
    end

    // Spill register state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spill_full_q <= 1'b0;
            spill_id_q   <= {ExtIdWidth{1'b0}};
            spill_data_q <= {DataWidth{1'b0}};
            spill_err_q  <= 1'b0;
        end else begin
            spill_full_q <= spill_full_d;
            spill_id_q   <= spill_id_d;
            spill_data_q <= spill_data_d;
            spill_err_q  <= spill_err_d;
        end
    end
`else
    // An empty FIFO means the response has no owner: accept and drop it.
    assign bus.slv_p_valid = bus.acc_p_valid & ~empty_s;
    assign bus.acc_p_ready = bus.slv_p_ready | empty_s;
    assign bus.slv_p_id    = head_id_s;
    assign bus.slv_p_data  = rsp_data_s;
    assign bus.slv_p_error = bus.acc_p_error;
    assign pop_s           = bus.acc_p_valid & bus.acc_p_ready & ~empty_s;
`endif

endmodule

// File: tb/tb_acc_rsp_id_tracker.sv
// Scenario bench for acc_rsp_id_tracker; expected responses are queued when the
// accelerator hands them over and compared when they leave on the slave port.
module tb_acc_rsp_id_tracker;
    import acc_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int IW    = 2;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef ACC_RSP_ID_TRACKER_SPILL_EN
    localparam logic [CW-1:0] HOLD_CNT = CW'(0);
`else
    localparam logic [CW-1:0] HOLD_CNT = CW'(1);
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] outstanding;
    logic          spurious;
    int            n_cmp = 0;
    int            n_bad = 0;
    ext_id_t       id_model[$];
    acc_rsp_chan_t exp_q[$];
    acc_rsp_chan_t mon_e;

    always #5 clk = ~clk;

    acc_rsp_id_tracker_if #(.DataWidth(DW), .ExtIdWidth(IW)) bus ();

    acc_rsp_id_tracker #(.DataWidth(DW), .ExtIdWidth(IW), .Depth(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .outstanding_o(outstanding), .spurious_o(spurious)
    );

    // Output monitor: every slave-side handshake must match the oldest expected response.
    initial forever begin
        @(negedge clk);
        #3;
        if (bus.slv_p_valid === 1'b1 && bus.slv_p_ready === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rsp_unexpected: got id=%0d data=%h, required no response", bus.slv_p_id, bus.slv_p_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.slv_p_id, bus.slv_p_data, bus.slv_p_error} !== {mon_e.id, mon_e.data, mon_e.error}) begin
                    n_bad++;
                    $display("FAIL rsp_payload: got id=%0d data=%h err=%b, required id=%0d data=%h err=%b",
                             bus.slv_p_id, bus.slv_p_data, bus.slv_p_error, mon_e.id, mon_e.data, mon_e.error);
                end
            end
        end
    end

    task automatic idle();
        bus.slv_q_valid = 1'b0; bus.slv_q_wb = 1'b0; bus.slv_q_id = 2'd0; bus.acc_q_ready = 1'b1;
        bus.acc_p_valid = 1'b0; bus.acc_p_data = 32'd0; bus.acc_p_error = 1'b0; bus.slv_p_ready = 1'b1;
    endtask

    task automatic drive_req(input logic wb, input ext_id_t id);
        bus.slv_q_valid = 1'b1; bus.slv_q_wb = wb; bus.slv_q_id = id;
    endtask

    task automatic drive_rsp(input logic [DW-1:0] data, input logic err);
        bus.acc_p_valid = 1'b1; bus.acc_p_data = data; bus.acc_p_error = err;
    endtask

    // Reference model update for the current cycle (called after the cycle's checks).
    task automatic model_cycle();
        logic    req_acc, rsp_acc;
        ext_id_t head;
        req_acc = bus.slv_q_valid & bus.slv_q_wb & bus.acc_q_ready & (id_model.size() < DEPTH);
        rsp_acc = bus.acc_p_valid & bus.acc_p_ready & (id_model.size() > 0);
        if (rsp_acc) begin
            head = id_model.pop_front();
            exp_q.push_back('{data: bus.acc_p_data, error: bus.acc_p_error, id: head});
        end
        if (req_acc) id_model.push_back(bus.slv_q_id);
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        drive_req(1'b1, 2'd3);
        #1;
        n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL rst_outstanding: got %0d required 0", outstanding); end
        n_cmp++; if (bus.slv_p_valid !== 1'b0) begin n_bad++; $display("FAIL rst_p_valid: got %b required 0", bus.slv_p_valid); end
        n_cmp++; if (spurious !== 1'b0) begin n_bad++; $display("FAIL rst_spurious: got %b required 0", spurious); end
        n_cmp++; if ({bus.slv_q_ready, bus.acc_q_valid} !== 2'b11) begin n_bad++; $display("FAIL rst_q_pass: got %b required 11", {bus.slv_q_ready, bus.acc_q_valid}); end
        @(negedge clk);
        rst = 1'b0; idle();
        #1;
        n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL rst_release_cnt: got %0d required 0", outstanding); end
    endtask

    task automatic test_in_order();
        ext_id_t ids [3];
        ids = '{2'd2, 2'd1, 2'd3};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); drive_req(1'b1, ids[i]); #1;
            n_cmp++; if ({bus.slv_q_ready, bus.acc_q_valid} !== 2'b11) begin n_bad++; $display("FAIL order_push_rdy: got %b required 11", {bus.slv_q_ready, bus.acc_q_valid}); end
            n_cmp++; if (outstanding !== CW'(i)) begin n_bad++; $display("FAIL order_push_cnt: got %0d required %0d", outstanding, i); end
            model_cycle();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); drive_rsp(32'hA + 32'(i), 1'b0); #1;
            n_cmp++; if (bus.acc_p_ready !== 1'b1) begin n_bad++; $display("FAIL order_p_ready: got %b required 1", bus.acc_p_ready); end
            n_cmp++; if (outstanding !== CW'(3 - i)) begin n_bad++; $display("FAIL order_pop_cnt: got %0d required %0d", outstanding, 3 - i); end
`ifdef ACC_RSP_ID_TRACKER_SPILL_EN
            n_cmp++; if (bus.slv_p_valid !== (i > 0)) begin n_bad++; $display("FAIL spill_valid: got %b required %b", bus.slv_p_valid, (i > 0)); end
            if (i > 0) begin
                n_cmp++; if (bus.slv_p_id !== ids[i-1]) begin n_bad++; $display("FAIL spill_id: got %0d required %0d", bus.slv_p_id, ids[i-1]); end
            end
`else
            n_cmp++; if ({bus.slv_p_valid, bus.slv_p_id} !== {1'b1, ids[i]}) begin n_bad++; $display("FAIL order_id: got %b/%0d required 1/%0d", bus.slv_p_valid, bus.slv_p_id, ids[i]); end
`endif
            model_cycle();
        end
        @(negedge clk); idle(); #1;
        n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL order_final_cnt: got %0d required 0", outstanding); end
`ifdef ACC_RSP_ID_TRACKER_SPILL_EN
        n_cmp++; if ({bus.slv_p_valid, bus.slv_p_id} !== {1'b1, ids[2]}) begin n_bad++; $display("FAIL spill_last: got %b/%0d required 1/%0d", bus.slv_p_valid, bus.slv_p_id, ids[2]); end
`endif
        model_cycle();
        @(negedge clk); idle(); #1; model_cycle();
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk); idle(); drive_req(1'b1, ext_id_t'(i)); #1;
            n_cmp++; if (bus.slv_q_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready: got %b required 1", bus.slv_q_ready); end
            model_cycle();
        end
        @(negedge clk); idle(); drive_req(1'b1, 2'd2); #1;
        n_cmp++; if ({bus.slv_q_ready, bus.acc_q_valid} !== 2'b00) begin n_bad++; $display("FAIL full_block: got %b required 00", {bus.slv_q_ready, bus.acc_q_valid}); end
        n_cmp++; if (outstanding !== CW'(DEPTH)) begin n_bad++; $display("FAIL full_cnt: got %0d required %0d", outstanding, DEPTH); end
        model_cycle();
        @(negedge clk); idle(); drive_req(1'b0, 2'd2); #1;
        n_cmp++; if ({bus.slv_q_ready, bus.acc_q_valid} !== 2'b11) begin n_bad++; $display("FAIL full_nowb_pass: got %b required 11", {bus.slv_q_ready, bus.acc_q_valid}); end
        model_cycle();
        @(negedge clk); idle(); #1;
        n_cmp++; if (outstanding !== CW'(DEPTH)) begin n_bad++; $display("FAIL full_nowb_cnt: got %0d required %0d", outstanding, DEPTH); end
        model_cycle();
    endtask

    task automatic test_pop_push_at_full();
        @(negedge clk); idle(); drive_req(1'b1, 2'd1); drive_rsp(32'h100, 1'b0); #1;
        n_cmp++; if ({bus.slv_q_ready, bus.acc_p_ready} !== 2'b01) begin n_bad++; $display("FAIL pp_same_cycle: got %b required 01", {bus.slv_q_ready, bus.acc_p_ready}); end
        model_cycle();
        @(negedge clk); idle(); drive_req(1'b1, 2'd1); #1;
        n_cmp++; if (bus.slv_q_ready !== 1'b1) begin n_bad++; $display("FAIL pp_next_ready: got %b required 1", bus.slv_q_ready); end
        n_cmp++; if (outstanding !== CW'(DEPTH - 1)) begin n_bad++; $display("FAIL pp_cnt3: got %0d required %0d", outstanding, DEPTH - 1); end
        model_cycle();
        @(negedge clk); idle(); #1;
        n_cmp++; if (outstanding !== CW'(DEPTH)) begin n_bad++; $display("FAIL pp_cnt4: got %0d required %0d", outstanding, DEPTH); end
        model_cycle();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk); idle(); drive_rsp(32'h200 + 32'(i), i[0]); #1;
            n_cmp++; if (bus.acc_p_ready !== 1'b1) begin n_bad++; $display("FAIL drain_ready: got %b required 1", bus.acc_p_ready); end
            model_cycle();
        end
        repeat (2) begin @(negedge clk); idle(); #1; model_cycle(); end
        n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL drain_cnt: got %0d required 0", outstanding); end
    endtask

    task automatic test_spurious();
        @(negedge clk); idle(); drive_rsp(32'hDEAD, 1'b0); #1;
        n_cmp++; if ({bus.acc_p_ready, bus.slv_p_valid, spurious} !== 3'b101) begin n_bad++; $display("FAIL spur_pulse: got %b required 101", {bus.acc_p_ready, bus.slv_p_valid, spurious}); end
        model_cycle();
        @(negedge clk); idle(); #1;
        n_cmp++; if ({spurious, bus.slv_p_valid} !== 2'b00) begin n_bad++; $display("FAIL spur_after: got %b required 00", {spurious, bus.slv_p_valid}); end
        n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL spur_cnt: got %0d required 0", outstanding); end
        model_cycle();
    endtask

    task automatic test_backpressure();
        @(negedge clk); idle(); drive_req(1'b1, 2'd1); #1; model_cycle();
        @(negedge clk); idle(); drive_rsp(32'h55, 1'b0); bus.slv_p_ready = 1'b0; #1;
`ifdef ACC_RSP_ID_TRACKER_SPILL_EN
        n_cmp++; if ({bus.acc_p_ready, bus.slv_p_valid} !== 2'b10) begin n_bad++; $display("FAIL bp_first: got %b required 10", {bus.acc_p_ready, bus.slv_p_valid}); end
`else
        n_cmp++; if ({bus.acc_p_ready, bus.slv_p_valid} !== 2'b01) begin n_bad++; $display("FAIL bp_first: got %b required 01", {bus.acc_p_ready, bus.slv_p_valid}); end
`endif
        model_cycle();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
`ifdef ACC_RSP_ID_TRACKER_SPILL_EN
            bus.acc_p_valid = 1'b0;
`endif
            #1;
            n_cmp++; if ({bus.slv_p_valid, bus.slv_p_id, bus.slv_p_data} !== {1'b1, 2'd1, 32'h55}) begin n_bad++; $display("FAIL bp_hold: got %b/%0d/%h required 1/1/55", bus.slv_p_valid, bus.slv_p_id, bus.slv_p_data); end
            n_cmp++; if (outstanding !== HOLD_CNT) begin n_bad++; $display("FAIL bp_hold_cnt: got %0d required %0d", outstanding, HOLD_CNT); end
            model_cycle();
        end
        @(negedge clk); bus.slv_p_ready = 1'b1; #1;
        n_cmp++; if (bus.slv_p_valid !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b required 1", bus.slv_p_valid); end
        model_cycle();
        @(negedge clk); idle(); #1;
        n_cmp++; if ({bus.slv_p_valid, outstanding} !== {1'b0, 3'd0}) begin n_bad++; $display("FAIL bp_single_pop: got %b/%0d required 0/0", bus.slv_p_valid, outstanding); end
        model_cycle();
    endtask

    task automatic test_reset_mid();
        @(negedge clk); idle(); drive_req(1'b1, 2'd3); #1; model_cycle();
        @(negedge clk); idle(); drive_req(1'b1, 2'd0); #1; model_cycle();
        @(negedge clk); idle(); #1;
        n_cmp++; if (outstanding !== 3'd2) begin n_bad++; $display("FAIL mid_pre_cnt: got %0d required 2", outstanding); end
        @(negedge clk); idle(); rst = 1'b1;
        @(negedge clk); rst = 1'b0; id_model.delete(); #1;
        n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL mid_rst_cnt: got %0d required 0", outstanding); end
        @(negedge clk); idle(); drive_rsp(32'h77, 1'b0); #1;
        n_cmp++; if ({spurious, bus.slv_p_valid} !== 2'b10) begin n_bad++; $display("FAIL mid_spurious: got %b required 10", {spurious, bus.slv_p_valid}); end
        model_cycle();
        @(negedge clk); idle(); #1; model_cycle();
    endtask

    task automatic test_back_to_back();
        logic rsp_hold = 1'b0;
        logic full_m, empty_m;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            bus.slv_q_valid = 1'($urandom_range(0, 1));
            bus.slv_q_wb    = 1'($urandom_range(0, 3) != 0);
            bus.slv_q_id    = 2'($urandom_range(0, 3));
            bus.acc_q_ready = 1'($urandom_range(0, 3) != 0);
            bus.slv_p_ready = 1'($urandom_range(0, 3) != 0);
            if (!rsp_hold) begin
                bus.acc_p_valid = 1'($urandom_range(0, 1));
                bus.acc_p_data  = $urandom;
                bus.acc_p_error = 1'($urandom_range(0, 1));
            end
            #1;
            full_m  = (id_model.size() == DEPTH);
            empty_m = (id_model.size() == 0);
            n_cmp++; if (bus.slv_q_ready !== (bus.acc_q_ready & ~(bus.slv_q_wb & full_m))) begin n_bad++; $display("FAIL b2b_q_ready: got %b cycle %0d", bus.slv_q_ready, c); end
            n_cmp++; if (bus.acc_q_valid !== (bus.slv_q_valid & ~(bus.slv_q_wb & full_m))) begin n_bad++; $display("FAIL b2b_q_valid: got %b cycle %0d", bus.acc_q_valid, c); end
            n_cmp++; if (outstanding !== CW'(id_model.size())) begin n_bad++; $display("FAIL b2b_cnt: got %0d required %0d", outstanding, id_model.size()); end
            n_cmp++; if (spurious !== (bus.acc_p_valid & empty_m)) begin n_bad++; $display("FAIL b2b_spurious: got %b required %b", spurious, bus.acc_p_valid & empty_m); end
`ifndef ACC_RSP_ID_TRACKER_SPILL_EN
            n_cmp++; if (bus.acc_p_ready !== (bus.slv_p_ready | empty_m)) begin n_bad++; $display("FAIL b2b_p_ready: got %b required %b", bus.acc_p_ready, bus.slv_p_ready | empty_m); end
`endif
            rsp_hold = bus.acc_p_valid & ~bus.acc_p_ready;
            model_cycle();
        end
        @(negedge clk); idle(); #1; model_cycle();
    endtask

    initial begin
        int waited;
        test_reset();
        test_in_order();
        test_full();
        test_pop_push_at_full();
        test_spurious();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge clk); idle(); #1; model_cycle();
            waited++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d responses pending, required 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
